// File: rtl/sigmoid_backprop.sv
// Sigmoid backward pass: dx = g * y * (1 - y) per lane, sequenced through
// single-precision add/mul units with a start/done handshake.
package sigmoid_fp_pkg;
  // Round-to-nearest-even and pack; returns {overflow, result}. Underflow flushes to signed zero.
  function automatic logic [32:0] round_pack(input logic sign, input logic signed [9:0] exp_in,
                                             input logic [22:0] mant, input logic guard,
                                             input logic sticky);
    logic [23:0]       m;
    logic signed [9:0] e;
    m = {1'b0, mant} + {23'd0, guard & (sticky | mant[0])};
    e = m[23] ? exp_in + 10'sd1 : exp_in;
    if (e >= 10'sd255)    round_pack = {1'b1, sign, 8'hff, 23'd0};
    else if (e <= 10'sd0) round_pack = {1'b0, sign, 31'd0};
    else                  round_pack = {1'b0, sign, e[7:0], m[22:0]};
  endfunction
endpackage

module add_float (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        done,
  output logic        nan,
  output logic        overflow
);
  import sigmoid_fp_pkg::*;

  logic [31:0] res_q, res_d;
  logic        done_q, done_d, nan_q, nan_d, ovf_q, ovf_d;
  logic        sb, swap, sl, ss, sticky;
  logic [7:0]  el, es, dexp;
  logic [22:0] ml, ms;
  logic [50:0] xl, xs0, xs, sum;
  logic [48:0] sn;
  logic [5:0]  lz;
  logic [32:0] rp;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign a_zero = (a[30:23] == 8'd0);
  assign b_zero = (b[30:23] == 8'd0);
  assign a_inf  = (a[30:23] == 8'hff) && (a[22:0] == 23'd0);
  assign b_inf  = (b[30:23] == 8'hff) && (b[22:0] == 23'd0);
  assign a_nan  = (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
  assign b_nan  = (b[30:23] == 8'hff) && (b[22:0] != 23'd0);

  always_comb begin
    res_d  = res_q;
    nan_d  = nan_q;
    ovf_d  = ovf_q;
    done_d = 1'b0;
    sb     = b[31] ^ op;
    swap   = b[30:0] > a[30:0];
    sl     = swap ? sb : a[31];
    ss     = swap ? a[31] : sb;
    el     = swap ? b[30:23] : a[30:23];
    es     = swap ? a[30:23] : b[30:23];
    ml     = swap ? b[22:0] : a[22:0];
    ms     = swap ? a[22:0] : b[22:0];
    dexp   = el - es;
    xl     = {2'b01, ml, 26'd0};
    xs0    = {2'b01, ms, 26'd0};
    xs     = xs0 >> dexp;
    // Bits shifted out of the smaller operand collapse into a sticky LSB far below the round bit.
    sticky = (xs << dexp) != xs0;
    xs[0]  = xs[0] | sticky;
    sum    = (sl == ss) ? xl + xs : xl - xs;
    lz     = 6'd0;
    for (int i = 0; i < 50; i++) begin
      if (sum[i]) lz = 6'(49 - i);
    end
    sn = 49'(sum << lz);
    if (sum[50]) rp = round_pack(sl, $signed({2'b00, el}) + 10'sd1, sum[49:27], sum[26], |sum[25:0]);
    else         rp = round_pack(sl, $signed({2'b00, el}) - $signed({4'd0, lz}), sn[48:26], sn[25], |sn[24:0]);
    if (start) begin
      done_d = 1'b1;
      nan_d  = 1'b0;
      ovf_d  = 1'b0;
      if (a_nan || b_nan || (a_inf && b_inf && (a[31] != sb))) begin
        res_d = 32'h7fc00000;
        nan_d = 1'b1;
      end else if (a_inf)           res_d = a;
      else if (b_inf)               res_d = {sb, b[30:0]};
      else if (a_zero && b_zero)    res_d = {a[31] & sb, 31'd0};
      else if (a_zero)              res_d = {sb, b[30:0]};
      else if (b_zero)              res_d = a;
      else if (sum == 51'd0)        res_d = 32'd0;
      else begin
        res_d = rp[31:0];
        ovf_d = rp[32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q  <= 32'd0;
      done_q <= 1'b0;
      nan_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      res_q  <= res_d;
      done_q <= done_d;
      nan_q  <= nan_d;
      ovf_q  <= ovf_d;
    end
  end

  assign result   = res_q;
  assign done     = done_q;
  assign nan      = nan_q;
  assign overflow = ovf_q;
endmodule

module mul_float (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        done,
  output logic        nan,
  output logic        overflow,
  output logic        zero
);
  import sigmoid_fp_pkg::*;

  logic [31:0]       res_q, res_d;
  logic              done_q, done_d, nan_q, nan_d, ovf_q, ovf_d, zero_q, zero_d;
  logic              s;
  logic [47:0]       prod;
  logic signed [9:0] e;
  logic [32:0]       rp;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign a_zero = (a[30:23] == 8'd0);
  assign b_zero = (b[30:23] == 8'd0);
  assign a_inf  = (a[30:23] == 8'hff) && (a[22:0] == 23'd0);
  assign b_inf  = (b[30:23] == 8'hff) && (b[22:0] == 23'd0);
  assign a_nan  = (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
  assign b_nan  = (b[30:23] == 8'hff) && (b[22:0] != 23'd0);

  always_comb begin
    res_d  = res_q;
    nan_d  = nan_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    done_d = 1'b0;
    s      = a[31] ^ b[31];
    prod   = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e      = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (prod[47]) rp = round_pack(s, e + 10'sd1, prod[46:24], prod[23], |prod[22:0]);
    else          rp = round_pack(s, e, prod[45:23], prod[22], |prod[21:0]);
    if (start) begin
      done_d = 1'b1;
      nan_d  = 1'b0;
      ovf_d  = 1'b0;
      zero_d = 1'b0;
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
        res_d = 32'h7fc00000;
        nan_d = 1'b1;
      end else if (a_inf || b_inf) begin
        res_d = {s, 8'hff, 23'd0};
      end else if (a_zero || b_zero) begin
        res_d  = {s, 31'd0};
        zero_d = 1'b1;
      end else begin
        res_d  = rp[31:0];
        ovf_d  = rp[32];
        zero_d = (rp[30:0] == 31'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q  <= 32'd0;
      done_q <= 1'b0;
      nan_q  <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      res_q  <= res_d;
      done_q <= done_d;
      nan_q  <= nan_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign result   = res_q;
  assign done     = done_q;
  assign nan      = nan_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
endmodule

module sigmoid_backprop #(
  parameter int S = 32,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [S*N-1:0] y,
  input  logic [S*N-1:0] g,
  output logic [S*N-1:0] dx,
  output logic         busy,
  output logic         done,
  output logic         err
);
  typedef enum logic [2:0] {
    IDLE, SUB_GO, SUB_WAIT, MUL1_GO, MUL1_WAIT, MUL2_GO, MUL2_WAIT, DONE
  } state_t;

  state_t         state_q, state_d;
  logic [S*N-1:0] y_q, y_d, g_q, g_d, s_q, s_d, p_q, p_d, dx_q, dx_d;
  logic [N-1:0]   seen_q, seen_d;
  logic           err_q, err_d, busy_q, busy_d, done_q, done_d;
  logic [S*N-1:0] sub_res, mul_res, mul_a, mul_b;
  logic [N-1:0]   sub_done, sub_nan, sub_ovf, mul_done, mul_nan, mul_ovf, mul_zero;
  logic [N-1:0]   unit_done, unit_flag;
  logic           all_done, sub_start, mul_start;

  assign sub_start = (state_q == SUB_GO);
  assign mul_start = (state_q == MUL1_GO) || (state_q == MUL2_GO);
  // The multiplier is reused: y*(1-y) first, then g*(previous product).
  assign mul_a = (state_q == MUL2_GO) ? g_q : y_q;
  assign mul_b = (state_q == MUL2_GO) ? p_q : s_q;

  for (genvar i = 0; i < N; i++) begin : g_lane
    add_float u_sub (
      .clk(clk), .rst_n(~rst), .start(sub_start), .op(1'b1),
      .a(32'h3f800000), .b(y_q[S*i +: S]),
      .result(sub_res[S*i +: S]), .done(sub_done[i]), .nan(sub_nan[i]), .overflow(sub_ovf[i])
    );
    mul_float u_mul (
      .clk(clk), .rst_n(~rst), .start(mul_start),
      .a(mul_a[S*i +: S]), .b(mul_b[S*i +: S]),
      .result(mul_res[S*i +: S]), .done(mul_done[i]), .nan(mul_nan[i]),
      .overflow(mul_ovf[i]), .zero(mul_zero[i])
    );
  end

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    g_d       = g_q;
    s_d       = s_q;
    p_d       = p_q;
    dx_d      = dx_q;
    err_d     = err_q;
    seen_d    = seen_q;
    unit_done = (state_q == SUB_WAIT) ? sub_done : mul_done;
    unit_flag = (state_q == SUB_WAIT) ? (sub_nan | sub_ovf) : (mul_nan | mul_ovf);
    all_done  = &(seen_q | unit_done);
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = SUB_GO;
          y_d     = y;
          g_d     = g;
          err_d   = 1'b0;
        end
      end
      SUB_GO: begin
        seen_d  = '0;
        state_d = SUB_WAIT;
      end
      MUL1_GO: begin
        seen_d  = '0;
        state_d = MUL1_WAIT;
      end
      MUL2_GO: begin
        seen_d  = '0;
        state_d = MUL2_WAIT;
      end
      SUB_WAIT, MUL1_WAIT, MUL2_WAIT: begin
        seen_d = seen_q | unit_done;
        err_d  = err_q | (|(unit_done & unit_flag));
        if (all_done) begin
          if (state_q == SUB_WAIT) begin
            s_d     = sub_res;
            state_d = MUL1_GO;
          end else if (state_q == MUL1_WAIT) begin
            p_d     = mul_res;
            state_d = MUL2_GO;
          end else begin
            // A zero product is reported as +0 regardless of operand signs.
            for (int i = 0; i < N; i++) begin
              dx_d[S*i +: S] = mul_zero[i] ? '0 : mul_res[S*i +: S];
            end
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      g_q     <= '0;
      s_q     <= '0;
      p_q     <= '0;
      dx_q    <= '0;
      seen_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      g_q     <= g_d;
      s_q     <= s_d;
      p_q     <= p_d;
      dx_q    <= dx_d;
      seen_q  <= seen_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dx   = dx_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
endmodule

// File: tb/tb_sigmoid_backprop.sv
// Randomized bench for sigmoid_backprop (two lanes) against a real-arithmetic model.
module tb_sigmoid_backprop;
  localparam int LAT = 4 + 1 + 1 + 1;

  logic        clk, rst, start, busy, done, err;
  logic [63:0] y, g, dx;
  int          n_tests = 0, n_fail = 0, cyc = 0, done_cnt = 0;

  sigmoid_backprop #(.S(32), .N(2)) dut (
    .clk(clk), .rst(rst), .start(start), .y(y), .g(g),
    .dx(dx), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] f);
    if (f[30:0] == 31'd0) return 0.0;
    return $bitstoreal({f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0});
  endfunction

  // Round a double to single precision, nearest-even; operands are kept in the normal range.
  function automatic logic [31:0] to_single(input real r);
    logic [63:0] d;
    int          ee;
    logic        up;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    ee = int'(d[62:52]) - 896;
    up = d[28] && ((|d[27:0]) || d[29]);
    return {d[63], ee[7:0], d[51:29]} + {31'd0, up};
  endfunction

  function automatic logic [31:0] ref_lane(input logic [31:0] yv, input logic [31:0] gv);
    logic [31:0] s, p, d;
    s = to_single(1.0 - f2r(yv));
    p = to_single(f2r(yv) * f2r(s));
    d = to_single(f2r(gv) * f2r(p));
    return (d[30:0] == 31'd0) ? 32'd0 : d;
  endfunction

  function automatic logic [63:0] ref_dx(input logic [63:0] yv, input logic [63:0] gv);
    return {ref_lane(yv[63:32], gv[63:32]), ref_lane(yv[31:0], gv[31:0])};
  endfunction

  function automatic logic [31:0] rand_y();
    return {1'b0, 8'($urandom_range(126, 100)), 23'($urandom)};
  endfunction

  function automatic logic [31:0] rand_g();
    return {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
  endfunction

  task automatic run_txn(input logic [63:0] yv, input logic [63:0] gv, input bit dbl,
                         output logic [63:0] dxo, output logic erro, output int lat);
    int dc0;
    bit seen;
    @(negedge clk);
    y = yv; g = gv; start = 1'b1;
    lat = -1; seen = 1'b0;
    dc0 = done_cnt;
    begin : wait_loop
      int t0;
      t0 = cyc;
      for (int k = 1; k <= 40 && !seen; k++) begin
        @(negedge clk);
        if (k == 1) begin
          chk("busy_after_start", {63'd0, busy}, 64'd1);
          start = 1'b0;
          y = {rand_y(), rand_y()};
          g = {rand_g(), rand_g()};
        end
        if (k == 2 && dbl) start = 1'b1;
        if (k == 3) start = 1'b0;
        if (done) begin
          seen = 1'b1;
          lat  = cyc - t0;
        end
      end
    end
    chk("done_seen", {63'd0, seen}, 64'd1);
    dxo  = dx;
    erro = err;
    @(negedge clk);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("busy_idle", {63'd0, busy}, 64'd0);
    chk("done_count", 64'(done_cnt - dc0), 64'd1);
  endtask

  logic [63:0] yv, gv, dxo;
  logic        erro;
  int          lat, dc0;

  initial begin
    rst = 1'b1; start = 1'b0; y = '0; g = '0;
    repeat (3) @(negedge clk);
    chk("reset_dx", dx, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_err", {63'd0, err}, 64'd0);
    rst = 1'b0;

    run_txn({32'h3f400000, 32'h3f000000}, {32'h40000000, 32'h3f800000}, 1'b0, dxo, erro, lat);
    chk("basic_dx", dxo, {32'h3ec00000, 32'h3e800000});
    chk("basic_err", {63'd0, erro}, 64'd0);
    chk("basic_latency", 64'(lat), 64'(LAT));

    yv = {rand_y(), 32'h3e800000};
    gv = {rand_g(), 32'hc0800000};
    run_txn(yv, gv, 1'b0, dxo, erro, lat);
    chk("neg_dx_lane0", {32'd0, dxo[31:0]}, 64'h00000000bf400000);
    chk("neg_dx_lane1", {32'd0, dxo[63:32]}, {32'd0, ref_lane(yv[63:32], gv[63:32])});

    run_txn({32'h00000000, 32'h3f800000}, {32'hbf800000, 32'h40400000}, 1'b0, dxo, erro, lat);
    chk("zero_dx", dxo, 64'd0);
    chk("zero_err", {63'd0, erro}, 64'd0);

    yv = {rand_y(), rand_y()};
    gv = {rand_g(), rand_g()};
    run_txn(yv, gv, 1'b1, dxo, erro, lat);
    chk("busy_start_dx", dxo, ref_dx(yv, gv));
    chk("busy_start_latency", 64'(lat), 64'(LAT));

    // Reset while the first multiply is in flight.
    @(negedge clk);
    y = {rand_y(), rand_y()}; g = {rand_g(), rand_g()}; start = 1'b1;
    dc0 = done_cnt;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_dx", dx, 64'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrst_no_done", 64'(done_cnt - dc0), 64'd0);
    yv = {rand_y(), rand_y()};
    gv = {rand_g(), rand_g()};
    run_txn(yv, gv, 1'b0, dxo, erro, lat);
    chk("after_rst_dx", dxo, ref_dx(yv, gv));

    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_beats_start", {63'd0, busy}, 64'd0);

    yv = {rand_y(), 32'h3f000000};
    gv = {rand_g(), 32'h7fc00000};
    run_txn(yv, gv, 1'b0, dxo, erro, lat);
    chk("nan_err", {63'd0, erro}, 64'd1);
    chk("nan_other_lane", {32'd0, dxo[63:32]}, {32'd0, ref_lane(yv[63:32], gv[63:32])});
    yv = {rand_y(), rand_y()};
    gv = {rand_g(), rand_g()};
    run_txn(yv, gv, 1'b0, dxo, erro, lat);
    chk("clean_err", {63'd0, erro}, 64'd0);
    chk("clean_dx", dxo, ref_dx(yv, gv));

    for (int t = 0; t < 30; t++) begin
      yv = {rand_y(), rand_y()};
      gv = {rand_g(), rand_g()};
      run_txn(yv, gv, 1'b0, dxo, erro, lat);
      chk("rand_dx", dxo, ref_dx(yv, gv));
      chk("rand_err", {63'd0, erro}, 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
